// File: rtl/bus_cycle_checker_if.sv
// CPU bus tap bundle for the bus cycle checker.
// The bench side drives it and the checker only observes it.
interface bus_cycle_checker_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              phi2;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_rdata;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rw;

    modport master (
        output phi2, bus_addr, bus_rdata, bus_wdata, bus_rw
    );

    modport slave (
        input phi2, bus_addr, bus_rdata, bus_wdata, bus_rw
    );
endinterface

// File: rtl/bus_cycle_checker.sv
// Compares observed cpu6502 bus cycles against a preloaded table
// of expected transactions, in strict or subsequence mode.
module bus_cycle_checker #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int MODE        = 0,
    parameter int STOP_ON_ERR = 1,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16,
    localparam int PW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    bus_cycle_checker_if.slave bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] load_mask,
    input  logic              load_rw,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              overflow,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [PW-1:0]     fail_index,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    FULL = PW'(DEPTH);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t            state;
    logic              phi2_q;
    logic [PW-1:0]     load_ptr;
    logic [PW-1:0]     chk_ptr;
    logic [CNT_W-1:0]  skip_cnt;

    logic [ADDR_W-1:0] tab_addr [DEPTH];
    logic [DATA_W-1:0] tab_data [DEPTH];
    logic [DATA_W-1:0] tab_mask [DEPTH];
    logic              tab_rw   [DEPTH];

    logic              ev;
    logic [DATA_W-1:0] obs_data;
    logic              hit;
    logic              load_ok;
    logic [PW-1:0]     load_nxt;
    logic [PW-1:0]     chk_inc;
    logic              done;
    logic [CNT_W-1:0]  cyc_inc;
    logic [CNT_W-1:0]  err_inc;

    assign busy = (state == RUN);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);

    // Event detection, table compare and next-pointer arithmetic.
    always_comb begin
        ev       = (bus.phi2 & ~phi2_q & ~bus.bus_rw)
                 | (~bus.phi2 & phi2_q & bus.bus_rw);
        obs_data = bus.bus_rw ? bus.bus_rdata : bus.bus_wdata;
        hit      = (bus.bus_addr == tab_addr[chk_ptr[AW-1:0]])
                 && (bus.bus_rw == tab_rw[chk_ptr[AW-1:0]])
                 && (((obs_data ^ tab_data[chk_ptr[AW-1:0]])
                      & tab_mask[chk_ptr[AW-1:0]]) == '0);
        load_ok  = reset && !clear && (state == IDLE)
                 && load_en && (load_ptr != FULL);
        load_nxt = load_ptr + PW'(load_ok);
        chk_inc  = chk_ptr + 1'b1;
        done     = (chk_inc == load_ptr);
        cyc_inc  = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
        err_inc  = (&err_count) ? err_count : err_count + 1'b1;
    end

    // Expected-transaction table; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            tab_addr[load_ptr[AW-1:0]] <= load_addr;
            tab_data[load_ptr[AW-1:0]] <= load_data;
            tab_mask[load_ptr[AW-1:0]] <= load_mask;
            tab_rw[load_ptr[AW-1:0]]   <= load_rw;
        end
    end

    // Checker FSM with registered verdict, counters and failure detail.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            phi2_q      <= 1'b0;
            load_ptr    <= '0;
            chk_ptr     <= '0;
            skip_cnt    <= '0;
            overflow    <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
            fail_index  <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            phi2_q <= bus.phi2;
            if (clear) begin
                state       <= IDLE;
                load_ptr    <= '0;
                chk_ptr     <= '0;
                skip_cnt    <= '0;
                overflow    <= 1'b0;
                err_count   <= '0;
                cycle_count <= '0;
                fail_index  <= '0;
                fail_addr   <= '0;
                fail_data   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        load_ptr <= load_nxt;
                        if (load_en && (load_ptr == FULL))
                            overflow <= 1'b1;
                        if (start) begin
                            chk_ptr     <= '0;
                            skip_cnt    <= '0;
                            err_count   <= '0;
                            cycle_count <= '0;
                            state       <= (load_nxt == '0) ? PASS : RUN;
                        end
                    end
                    RUN: begin
                        if (ev) begin
                            cycle_count <= cyc_inc;
                            if (MODE == 0) begin
                                if (hit) begin
                                    chk_ptr <= chk_inc;
                                    if (done)
                                        state <= (err_count == '0) ? PASS : FAIL;
                                end else begin
                                    err_count <= err_inc;
                                    if (err_count == '0) begin
                                        fail_index <= chk_ptr;
                                        fail_addr  <= bus.bus_addr;
                                        fail_data  <= obs_data;
                                    end
                                    if (STOP_ON_ERR != 0) begin
                                        state <= FAIL;
                                    end else begin
                                        chk_ptr <= chk_inc;
                                        if (done)
                                            state <= FAIL;
                                    end
                                end
                            end else begin
                                if (hit) begin
                                    chk_ptr  <= chk_inc;
                                    skip_cnt <= '0;
                                    if (done)
                                        state <= PASS;
                                end else if (skip_cnt >= TMO) begin
                                    state      <= FAIL;
                                    fail_index <= chk_ptr;
                                    fail_addr  <= bus.bus_addr;
                                    fail_data  <= obs_data;
                                end else begin
                                    skip_cnt <= skip_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_cycle_checker.sv
// Scenario bench for bus_cycle_checker: four configurations share
// one bus tap, each with its own load/start/clear controls.
module tb_bus_cycle_checker;
    typedef struct packed {
        logic        busy;
        logic        pass;
        logic        fail;
        logic        ovf;
        logic [15:0] err;
        logic [15:0] cyc;
        logic [4:0]  fidx;
        logic [15:0] faddr;
        logic [7:0]  fdata;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  load_en = '0;
    logic [3:0]  start = '0;
    logic [3:0]  clear = '0;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic [7:0]  ld_mask = '0;
    logic        ld_rw = 1'b0;

    logic        busy_o [4];
    logic        pass_o [4];
    logic        fail_o [4];
    logic        ovf_o  [4];
    logic [15:0] err_o  [4];
    logic [15:0] cyc_o  [4];
    logic [15:0] faddr_o[4];
    logic [7:0]  fdata_o[4];
    logic [4:0]  fidx_o [3];
    logic [2:0]  fidx3;

    int checks = 0;
    int failures = 0;
    res_t exp_q[$];

    bus_cycle_checker_if #(.ADDR_W(16), .DATA_W(8)) bif ();

    always #5 clk = ~clk;

    bus_cycle_checker #(.MODE(0), .STOP_ON_ERR(1)) u0 (
        .clk(clk), .reset(reset), .bus(bif),
        .load_en(load_en[0]), .load_addr(ld_addr), .load_data(ld_data),
        .load_mask(ld_mask), .load_rw(ld_rw), .start(start[0]),
        .clear(clear[0]), .busy(busy_o[0]), .pass(pass_o[0]),
        .fail(fail_o[0]), .overflow(ovf_o[0]), .err_count(err_o[0]),
        .cycle_count(cyc_o[0]), .fail_index(fidx_o[0]),
        .fail_addr(faddr_o[0]), .fail_data(fdata_o[0])
    );

    bus_cycle_checker #(.MODE(0), .STOP_ON_ERR(0)) u1 (
        .clk(clk), .reset(reset), .bus(bif),
        .load_en(load_en[1]), .load_addr(ld_addr), .load_data(ld_data),
        .load_mask(ld_mask), .load_rw(ld_rw), .start(start[1]),
        .clear(clear[1]), .busy(busy_o[1]), .pass(pass_o[1]),
        .fail(fail_o[1]), .overflow(ovf_o[1]), .err_count(err_o[1]),
        .cycle_count(cyc_o[1]), .fail_index(fidx_o[1]),
        .fail_addr(faddr_o[1]), .fail_data(fdata_o[1])
    );

    bus_cycle_checker #(.MODE(1), .TIMEOUT(2)) u2 (
        .clk(clk), .reset(reset), .bus(bif),
        .load_en(load_en[2]), .load_addr(ld_addr), .load_data(ld_data),
        .load_mask(ld_mask), .load_rw(ld_rw), .start(start[2]),
        .clear(clear[2]), .busy(busy_o[2]), .pass(pass_o[2]),
        .fail(fail_o[2]), .overflow(ovf_o[2]), .err_count(err_o[2]),
        .cycle_count(cyc_o[2]), .fail_index(fidx_o[2]),
        .fail_addr(faddr_o[2]), .fail_data(fdata_o[2])
    );

    bus_cycle_checker #(.DEPTH(4), .MODE(0), .STOP_ON_ERR(1)) u3 (
        .clk(clk), .reset(reset), .bus(bif),
        .load_en(load_en[3]), .load_addr(ld_addr), .load_data(ld_data),
        .load_mask(ld_mask), .load_rw(ld_rw), .start(start[3]),
        .clear(clear[3]), .busy(busy_o[3]), .pass(pass_o[3]),
        .fail(fail_o[3]), .overflow(ovf_o[3]), .err_count(err_o[3]),
        .cycle_count(cyc_o[3]), .fail_index(fidx3),
        .fail_addr(faddr_o[3]), .fail_data(fdata_o[3])
    );

    function automatic res_t obs(input int id);
        res_t r;
        r.busy  = busy_o[id];
        r.pass  = pass_o[id];
        r.fail  = fail_o[id];
        r.ovf   = ovf_o[id];
        r.err   = err_o[id];
        r.cyc   = cyc_o[id];
        r.fidx  = (id == 3) ? {2'b00, fidx3} : fidx_o[id];
        r.faddr = faddr_o[id];
        r.fdata = fdata_o[id];
        return r;
    endfunction

    function automatic res_t mk(
        input logic p, input logic f, input logic o,
        input logic [15:0] e, input logic [15:0] c,
        input logic [4:0] fi, input logic [15:0] fa, input logic [7:0] fd
    );
        res_t r;
        r.busy  = 1'b0;
        r.pass  = p;
        r.fail  = f;
        r.ovf   = o;
        r.err   = e;
        r.cyc   = c;
        r.fidx  = fi;
        r.faddr = fa;
        r.fdata = fd;
        return r;
    endfunction

    task automatic rst_all();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_clear(input int id);
        clear[id] = 1'b1;
        @(negedge clk);
        clear[id] = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(
        input int id, input logic rw, input logic [15:0] a,
        input logic [7:0] d, input logic [7:0] m, input bit st
    );
        load_en[id] = 1'b1;
        start[id]   = st;
        ld_rw       = rw;
        ld_addr     = a;
        ld_data     = d;
        ld_mask     = m;
        @(negedge clk);
        load_en[id] = 1'b0;
        start[id]   = 1'b0;
    endtask

    task automatic go(input int id);
        start[id] = 1'b1;
        @(negedge clk);
        start[id] = 1'b0;
    endtask

    task automatic load_t(input int id, input logic [7:0] m2);
        load(id, 1'b1, 16'h0000, 8'hA2, 8'hFF, 1'b0);
        load(id, 1'b1, 16'h0001, 8'h01, 8'hFF, 1'b0);
        load(id, 1'b0, 16'h0099, 8'h83, m2, 1'b0);
    endtask

    // One full phi2 period; rdata/wdata hold their values through both edges.
    task automatic bus_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d);
        bif.bus_rw    = rw;
        bif.bus_addr  = a;
        bif.bus_rdata = rw ? d : 8'hEE;
        bif.bus_wdata = rw ? 8'h11 : d;
        @(negedge clk);
        bif.phi2 = 1'b1;
        repeat (2) @(negedge clk);
        bif.phi2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_verdict(input int id, output bit to);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!busy_o[id]) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        res_t r;
        rst_all();
        for (int i = 0; i < 4; i++) begin
            r = obs(i);
            checks++;
            if (r !== res_t'(0)) begin
                failures++;
                $display("FAIL reset%0d got=%h exp=0", i, r);
            end
        end
    endtask

    task automatic test_strict_pass();
        res_t r, e;
        bit to;
        rst_all();
        load_t(0, 8'hFF);
        go(0);
        checks++;
        if (busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%b exp=1", busy_o[0]);
        end
        exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 16'h0000, 8'h00));
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b0, 16'h0099, 8'h83);
        wait_verdict(0, to);
        e = exp_q.pop_front();
        r = obs(0);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL strict_pass got=%h exp=%h to=%0d", r, e, to);
        end
        do_clear(0);
        r = obs(0);
        checks++;
        if (r !== res_t'(0)) begin
            failures++;
            $display("FAIL clear_from_pass got=%h exp=0", r);
        end
    endtask

    task automatic test_strict_fail();
        res_t r, e;
        bit to;
        rst_all();
        load_t(0, 8'hFF);
        go(0);
        exp_q.push_back(mk(0, 1, 0, 1, 3, 2, 16'h0099, 8'h84));
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b0, 16'h0099, 8'h84);
        wait_verdict(0, to);
        e = exp_q.pop_front();
        r = obs(0);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL strict_fail got=%h exp=%h to=%0d", r, e, to);
        end
    endtask

    task automatic test_count_continue();
        res_t r, e;
        bit to;
        rst_all();
        load_t(1, 8'hFF);
        go(1);
        exp_q.push_back(mk(0, 1, 0, 2, 3, 0, 16'h0000, 8'h55));
        bus_cycle(1'b1, 16'h0000, 8'h55);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b0, 16'h0099, 8'h00);
        wait_verdict(1, to);
        e = exp_q.pop_front();
        r = obs(1);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL count_continue got=%h exp=%h to=%0d", r, e, to);
        end
    endtask

    task automatic test_mask();
        res_t r, e;
        bit to;
        rst_all();
        load_t(0, 8'h80);
        go(0);
        exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 16'h0000, 8'h00));
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b0, 16'h0099, 8'h84);
        wait_verdict(0, to);
        e = exp_q.pop_front();
        r = obs(0);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL mask_pass got=%h exp=%h to=%0d", r, e, to);
        end
        do_clear(0);
        load_t(0, 8'h80);
        go(0);
        exp_q.push_back(mk(0, 1, 0, 1, 3, 2, 16'h0099, 8'h84));
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b1, 16'h0099, 8'h84);
        wait_verdict(0, to);
        e = exp_q.pop_front();
        r = obs(0);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL mask_rw got=%h exp=%h to=%0d", r, e, to);
        end
    endtask

    task automatic test_subsequence();
        res_t r, e;
        bit to;
        rst_all();
        load(2, 1'b0, 16'h0099, 8'h83, 8'hFF, 1'b0);
        go(2);
        exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 16'h0000, 8'h00));
        bus_cycle(1'b1, 16'h0010, 8'h11);
        bus_cycle(1'b1, 16'h0011, 8'h22);
        bus_cycle(1'b0, 16'h0099, 8'h83);
        wait_verdict(2, to);
        e = exp_q.pop_front();
        r = obs(2);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL subseq_pass got=%h exp=%h to=%0d", r, e, to);
        end
        do_clear(2);
        load(2, 1'b0, 16'h0099, 8'h83, 8'hFF, 1'b0);
        go(2);
        exp_q.push_back(mk(0, 1, 0, 0, 3, 0, 16'h0012, 8'h33));
        bus_cycle(1'b1, 16'h0010, 8'h11);
        bus_cycle(1'b1, 16'h0011, 8'h22);
        bus_cycle(1'b1, 16'h0012, 8'h33);
        wait_verdict(2, to);
        e = exp_q.pop_front();
        r = obs(2);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL subseq_timeout got=%h exp=%h to=%0d", r, e, to);
        end
    endtask

    task automatic test_overflow();
        res_t r, e;
        bit to;
        rst_all();
        load_t(3, 8'hFF);
        load(3, 1'b1, 16'h0100, 8'h10, 8'hFF, 1'b0);
        load(3, 1'b0, 16'h0200, 8'h55, 8'hFF, 1'b0);
        checks++;
        if (ovf_o[3] !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag got=%b exp=1", ovf_o[3]);
        end
        go(3);
        exp_q.push_back(mk(1, 0, 1, 0, 4, 0, 16'h0000, 8'h00));
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b0, 16'h0099, 8'h83);
        bus_cycle(1'b1, 16'h0100, 8'h10);
        wait_verdict(3, to);
        e = exp_q.pop_front();
        r = obs(3);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL overflow_run got=%h exp=%h to=%0d", r, e, to);
        end
    endtask

    task automatic test_reset_mid_run();
        res_t r;
        rst_all();
        load_t(0, 8'hFF);
        go(0);
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        r = obs(0);
        checks++;
        if (r !== res_t'(0)) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=0", r);
        end
    endtask

    task automatic test_empty_start();
        res_t r, e;
        rst_all();
        go(0);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
        e = exp_q.pop_front();
        r = obs(0);
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL empty_start got=%h exp=%h", r, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t r, e;
        bit to;
        rst_all();
        load(0, 1'b1, 16'h0000, 8'hA2, 8'hFF, 1'b0);
        load(0, 1'b1, 16'h0001, 8'h01, 8'hFF, 1'b0);
        load(0, 1'b0, 16'h0099, 8'h83, 8'hFF, 1'b1);
        exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 16'h0000, 8'h00));
        bus_cycle(1'b1, 16'h0000, 8'hA2);
        bus_cycle(1'b1, 16'h0001, 8'h01);
        bus_cycle(1'b0, 16'h0099, 8'h83);
        wait_verdict(0, to);
        e = exp_q.pop_front();
        r = obs(0);
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL load_with_start got=%h exp=%h to=%0d", r, e, to);
        end
    endtask

    initial begin
        bif.phi2      = 1'b0;
        bif.bus_addr  = '0;
        bif.bus_rdata = '0;
        bif.bus_wdata = '0;
        bif.bus_rw    = 1'b1;
        @(negedge clk);
        test_reset();
        test_strict_pass();
        test_strict_fail();
        test_count_continue();
        test_mask();
        test_subsequence();
        test_overflow();
        test_reset_mid_run();
        test_empty_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_cycle_checker.md
Name: bus_cycle_checker

Overview:
Synthesizable bus-transaction checker for cpu6502 benches. It replaces per-cycle ASSERT_AT timestamps with an expected-transaction table, which is loaded before the run and compared against observed CPU bus cycles. It sits beside the cpu6502 instance on addr/idata/odata/rw/clk2 and reports pass/fail, error count and first-failure detail. It generalises address/data width and table depth, adds masked data compare, and offers strict-sequence and subsequence matching modes.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 8, bus data width
DEPTH, 16, expected-table entries (>=1); PW = $clog2(DEPTH+1)
MODE, 0, 0 = strict (every bus cycle checked in order), 1 = subsequence (non-matching cycles skipped)
STOP_ON_ERR, 1, MODE 0 only: 1 = go FAIL at first mismatch, 0 = count and continue
TIMEOUT, 64, MODE 1 only: consecutive non-matching cycles allowed before FAIL
CNT_W, 16, width of counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low; state cleared on rising clk while low
phi2  in  1  CPU clk2 (phase-2) level, sampled by clk
bus_addr  in  ADDR_W  CPU address
bus_rdata  in  DATA_W  data into CPU (read cycles)
bus_wdata  in  DATA_W  data out of CPU (write cycles)
bus_rw  in  1  1 = read, 0 = write
load_en  in  1  write one table entry (IDLE only)
load_addr  in  ADDR_W  expected address
load_data  in  DATA_W  expected data
load_mask  in  DATA_W  compare mask, 1 = bit checked
load_rw  in  1  expected rw
start  in  1  pulse: IDLE -> RUN
clear  in  1  pulse: any state -> IDLE, table emptied
busy  out  1  state == RUN
pass  out  1  state == PASS
fail  out  1  state == FAIL
overflow  out  1  load attempted with table full (sticky until clear/reset)
err_count  out  CNT_W  mismatches counted (MODE 0)
cycle_count  out  CNT_W  bus events seen in RUN
fail_index  out  PW  table index of first failure
fail_addr  out  ADDR_W  observed address at first failure
fail_data  out  DATA_W  observed data at first failure

Behaviour:
- Reset (reset low at rising clk): state IDLE; load_ptr, chk_ptr, skip_cnt and all outputs 0; phi2_q = 0. Table RAM is not cleared; load_ptr = 0 makes it empty. Reset mid-RUN aborts without a verdict.
- Edge detect: phi2_q <= phi2 each clk. rise = phi2 & ~phi2_q; fall = ~phi2 & phi2_q.
- Bus event: write (bus_rw = 0) sampled in the rise cycle using bus_wdata; read (bus_rw = 1) sampled in the fall cycle using bus_rdata. No other sample points.
- Match: addr == exp_addr && rw == exp_rw && ((data ^ exp_data) & exp_mask) == 0.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - load_en with load_ptr < DEPTH writes entry[load_ptr] and increments load_ptr.
  - load_en with load_ptr == DEPTH drops the write and sets overflow.
  - start: load_ptr == 0 -> PASS; else -> RUN with chk_ptr = 0 and counters 0.
  - load_en and start in the same cycle: the entry is written and included (compare uses load_ptr + 1).
- RUN, per event: cycle_count++ (saturates at all-ones).
  - MODE 0 match: chk_ptr++.
  - MODE 0 mismatch: err_count++ (saturating). First mismatch latches fail_index/addr/data. If STOP_ON_ERR -> FAIL; else chk_ptr++.
  - MODE 1 match: chk_ptr++, skip_cnt = 0.
  - MODE 1 mismatch: skip_cnt++. When skip_cnt reaches TIMEOUT -> FAIL, latching fail_index = chk_ptr and the observed addr/data.
  - When chk_ptr would reach load_ptr: -> PASS if err_count (including this event) == 0, else FAIL.
- PASS/FAIL are terminal. Events are ignored, start and load_en are ignored; only clear or reset leave.
- clear in any state: IDLE, load_ptr/chk_ptr/counters/overflow/fail_* = 0. clear has priority over start, load_en and events in the same cycle.
- Latency: state and outputs are registered. pass/fail/busy change on the clk edge that ends the deciding event cycle, so they are visible in the following cycle.
- Edges in the cycle start is accepted are not checked; RUN begins the next cycle.
- start and load_en outside IDLE are ignored.

Test Plan:
- MODE 0, load {R 0000 A2 FF}, {R 0001 01 FF}, {W 0099 83 FF}, start, drive matching phi2 cycles -> pass = 1, err_count = 0, cycle_count = 3.
- Same table, write cycle carries data 84 -> fail = 1, fail_index = 2, fail_addr = 0099, fail_data = 84, err_count = 1.
- STOP_ON_ERR = 0, mismatches on entries 0 and 2 -> FAIL after 3 events, err_count = 2, fail_index = 0.
- Mask 80 on the write entry, write data 84 -> pass = 1. Write with rw = 1 on the same address -> fail.
- MODE 1, TIMEOUT = 2, table {W 0099 83 FF}: two unrelated reads then the match -> pass. Three unrelated reads -> fail, fail_index = 0.
- DEPTH = 4, five loads -> overflow = 1 and 4 entries checked. reset low mid-RUN -> busy = pass = fail = 0 the next cycle. start with an empty table -> pass.
